aes_dec_ctrl: RTL and testbench

Iterative AES-128 decryption round controller. Accepts one ciphertext block over a valid/ready handshake, applies the initial AddRoundKey with round key 10, then sequences ten inverse rounds through an external combinational round unit. The round unit performs InvShiftRows, InvSubBytes, AddRoundKey and InvMixColumns. Sits between the block interface and the inverse-round datapath; owns the 128-bit state register, round counter and round-key addressing.

---
 rtl/aes_dec_ctrl.sv | 91 +++++++++
 tb/tb_aes_dec_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_dec_ctrl.sv
// Iterative AES-128 decryption round controller: accepts a ciphertext block, applies the
// initial AddRoundKey, then walks an external inverse-round unit through NR rounds.
module aes_dec_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_addr,
  input  logic [127:0] rk_data,
  output logic [127:0] rnd_state,
  output logic         rnd_last,
  input  logic [127:0] rnd_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_e;

  localparam logic [3:0] NR_W = 4'(NR);

  fsm_e         fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [3:0]   round_q, round_d;
  logic [3:0]   rk_addr_q, rk_addr_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;
  logic         busy_q, busy_d;
  logic         rnd_last_q, rnd_last_d;

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    round_d = round_q;
    unique case (fsm_q)
      IDLE: if (in_valid) begin
        state_d = in_data ^ rk_data;
        round_d = NR_W - 4'd1;
        fsm_d   = ROUND;
      end
      ROUND: begin
        state_d = rnd_result;
        if (round_q == 4'd0) fsm_d = DONE;
        else                 round_d = round_q - 4'd1;
      end
      DONE: if (out_ready) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
    // Outputs are decoded from the next state so they can live in flops.
    in_ready_d  = (fsm_d == IDLE);
    out_valid_d = (fsm_d == DONE);
    busy_d      = (fsm_d != IDLE);
    rnd_last_d  = (fsm_d == ROUND) && (round_d == 4'd0);
    rk_addr_d   = (fsm_d == ROUND) ? round_d : NR_W;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      round_q     <= '0;
      rk_addr_q   <= NR_W;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      rnd_last_q  <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      round_q     <= round_d;
      rk_addr_q   <= rk_addr_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      rnd_last_q  <= rnd_last_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign rnd_last  = rnd_last_q;
  assign rk_addr   = rk_addr_q;
  assign rnd_state = state_q;
  assign out_data  = state_q;

endmodule

// File: tb/tb_aes_dec_ctrl.sv
// Bench for aes_dec_ctrl: behavioural inverse round unit and FIPS-197 key schedule around the DUT.
module tb_aes_dec_ctrl;

  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT2 = 128'hdeadbeef0123456789abcdeffedcba98;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   rk_addr;
  logic [127:0] rk_data;
  logic [127:0] rnd_state;
  logic         rnd_last;
  logic [127:0] rnd_result;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  logic [7:0]   sbox  [256];
  logic [7:0]   isbox [256];
  logic [127:0] rk_table [11];
  logic [127:0] rk_xor;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  aes_dec_ctrl #(.NR(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .rk_addr(rk_addr), .rk_data(rk_data),
    .rnd_state(rnd_state), .rnd_last(rnd_last), .rnd_result(rnd_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  // InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless last.
  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [7:0]   t [16];
    logic [7:0]   m [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] r;
    for (int row = 0; row < 4; row++)
      for (int col = 0; col < 4; col++)
        t[row + 4*col] = isbox[s[127 - 8*(row + 4*((col - row + 4) % 4)) -: 8]]
                         ^ k[127 - 8*(row + 4*col) -: 8];
    for (int col = 0; col < 4; col++) begin
      a0 = t[4*col]; a1 = t[4*col+1]; a2 = t[4*col+2]; a3 = t[4*col+3];
      if (last) begin
        m[4*col] = a0; m[4*col+1] = a1; m[4*col+2] = a2; m[4*col+3] = a3;
      end else begin
        m[4*col]   = gmul(a0,8'h0e)^gmul(a1,8'h0b)^gmul(a2,8'h0d)^gmul(a3,8'h09);
        m[4*col+1] = gmul(a0,8'h09)^gmul(a1,8'h0e)^gmul(a2,8'h0b)^gmul(a3,8'h0d);
        m[4*col+2] = gmul(a0,8'h0d)^gmul(a1,8'h09)^gmul(a2,8'h0e)^gmul(a3,8'h0b);
        m[4*col+3] = gmul(a0,8'h0b)^gmul(a1,8'h0d)^gmul(a2,8'h09)^gmul(a3,8'h0e);
      end
    end
    r = '0;
    for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = m[i];
    return r;
  endfunction

  function automatic logic [127:0] ref_dec(input logic [127:0] ct);
    logic [127:0] s;
    s = ct ^ rk_table[10];
    for (int r = 9; r >= 0; r--) s = inv_round(s, rk_table[r], r == 0);
    return s;
  endfunction

  assign rk_data    = ((rk_addr <= 4'd10) ? rk_table[rk_addr] : 128'h0) ^ rk_xor;
  assign rnd_result = inv_round(rnd_state, rk_data, rnd_last);

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after an edge; returns with the block accepted and the DUT in its first round cycle.
  task automatic send(input logic [127:0] ct);
    int n;
    n = 0;
    in_data  = ct;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 40) begin
      step();
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 128'(in_ready), 128'd1);
    step();
    in_valid = 1'b0;
  endtask

  // Called in the first round cycle; lat counts cycles from accept to out_valid.
  task automatic wait_out(output int lat);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      step();
      @(negedge clk);
      lat++;
    end
    if (!out_valid) chk("out_timeout", 128'(out_valid), 128'd1);
  endtask

  initial begin
    logic [7:0]   inv, rc;
    logic [31:0]  w [44];
    logic [31:0]  tw;
    logic [127:0] key_v, held;
    logic [127:0] outs [4];
    int           acc [4];
    int           lat, nacc, nout, cyc, pulses, n;

    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbox[a] = inv ^ rotl8(inv,1) ^ rotl8(inv,2) ^ rotl8(inv,3) ^ rotl8(inv,4) ^ 8'h63;
    end
    for (int a = 0; a < 256; a++) isbox[sbox[a]] = 8'(a);
    key_v = KEY;
    for (int i = 0; i < 4; i++) w[i] = key_v[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tw = w[i-1];
      if (i % 4 == 0) begin
        tw = {tw[23:0], tw[31:24]};
        tw = {sbox[tw[31:24]], sbox[tw[23:16]], sbox[tw[15:8]], sbox[tw[7:0]]} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ tw;
    end
    for (int r = 0; r < 11; r++) rk_table[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; rk_xor = '0;
    #12;
    chk("rst_in_ready",  128'(in_ready),  128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_busy",      128'(busy),      128'd0);
    chk("rst_rnd_last",  128'(rnd_last),  128'd0);
    chk("rst_rk_addr",   128'(rk_addr),   128'd10);
    chk("rst_out_data",  out_data,        128'd0);
    chk("rst_rnd_state", rnd_state,       128'd0);
    #10 rst_n = 1'b1;

    // FIPS vector with a full sequencing trace
    step();
    in_data = CT; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("acc_in_ready", 128'(in_ready), 128'd1);
    chk("acc_rk_addr",  128'(rk_addr),  128'd10);
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk($sformatf("trace_rk_addr%0d", k),  128'(rk_addr),   128'(10 - k));
      chk($sformatf("trace_rnd_last%0d", k), 128'(rnd_last),  128'(k == 10));
      chk($sformatf("trace_busy%0d", k),     128'(busy),      128'd1);
      chk($sformatf("trace_out_valid%0d", k),128'(out_valid), 128'd0);
      chk($sformatf("trace_in_ready%0d", k), 128'(in_ready),  128'd0);
      step();
    end
    @(negedge clk);
    chk("fips_out_valid", 128'(out_valid), 128'd1);
    chk("fips_out_data",  out_data,        PT);
    chk("fips_busy",      128'(busy),      128'd1);
    chk("fips_in_ready",  128'(in_ready),  128'd0);
    chk("fips_rnd_last",  128'(rnd_last),  128'd0);
    step();
    @(negedge clk);
    chk("post_out_valid", 128'(out_valid), 128'd0);
    chk("post_in_ready",  128'(in_ready),  128'd1);
    chk("post_busy",      128'(busy),      128'd0);

    // Backpressure: hold 5 cycles, second block and corrupted key bus offered meanwhile
    step();
    out_ready = 1'b0;
    send(CT);
    wait_out(lat);
    chk("bp_latency", 128'(lat), 128'd11);
    chk("bp_data",    out_data,  PT);
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 0) begin
        in_data = CT2; in_valid = 1'b1; rk_xor = 128'h5a5a_0f0f_3c3c_a5a5_1234_5678_9abc_def0;
      end
      @(negedge clk);
      chk($sformatf("bp_hold_valid%0d", i), 128'(out_valid), 128'd1);
      chk($sformatf("bp_hold_data%0d", i),  out_data,        held);
      chk($sformatf("bp_hold_ready%0d", i), 128'(in_ready),  128'd0);
    end
    step();
    out_ready = 1'b1; rk_xor = '0;
    @(negedge clk);
    chk("bp_hs_valid", 128'(out_valid), 128'd1);
    chk("bp_hs_ready", 128'(in_ready),  128'd0);
    step();
    @(negedge clk);
    chk("bp_idle_ready", 128'(in_ready),  128'd1);
    chk("bp_idle_valid", 128'(out_valid), 128'd0);
    step();
    in_valid = 1'b0;
    wait_out(lat);
    chk("bp2_latency", 128'(lat), 128'd11);
    chk("bp2_data",    out_data,  ref_dec(CT2));
    step();

    // Back-to-back with in_valid and out_ready tied high
    in_data = CT; in_valid = 1'b1; out_ready = 1'b1;
    nacc = 0; nout = 0; cyc = 0;
    while (nout < 2 && cyc < 80) begin
      @(negedge clk);
      if (in_valid && in_ready && nacc < 4) begin acc[nacc] = cyc; nacc++; end
      if (out_valid && nout < 4) begin outs[nout] = out_data; nout++; end
      step();
      cyc++;
      if (nacc == 1) in_data = '0;
    end
    in_valid = 1'b0;
    chk("b2b_outputs", 128'(nout), 128'd2);
    chk("b2b_accepts", 128'(nacc), 128'd2);
    chk("b2b_spacing", 128'(acc[1] - acc[0]), 128'd12);
    chk("b2b_data0",   outs[0], PT);
    chk("b2b_data1",   outs[1], ref_dec(128'h0));
    step();

    // Ignored input: in_valid toggles and in_data churns during rounds
    send(CT);
    for (int k = 0; k < 8; k++) begin
      in_valid = k[0];
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin step(); @(negedge clk); n++; end
    chk("ign_valid", 128'(out_valid), 128'd1);
    chk("ign_data",  out_data,        PT);
    step();

    // Asynchronous reset while rk_addr is 5
    send(CT);
    n = 0;
    @(negedge clk);
    while (rk_addr != 4'd5 && n < 20) begin step(); @(negedge clk); n++; end
    chk("mid_round5", 128'(rk_addr), 128'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_in_ready",  128'(in_ready),  128'd1);
    chk("mid_out_valid", 128'(out_valid), 128'd0);
    chk("mid_busy",      128'(busy),      128'd0);
    chk("mid_rnd_state", rnd_state,       128'd0);
    chk("mid_rk_addr",   128'(rk_addr),   128'd10);
    @(posedge clk);
    #3 rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid || busy) pulses++;
    end
    chk("mid_no_pulse", 128'(pulses), 128'd0);
    step();
    send(CT);
    wait_out(lat);
    chk("mid_next_latency", 128'(lat), 128'd11);
    chk("mid_next_data",    out_data,  PT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
